soml_frame_loader: RTL and testbench
====================================

// Module: soml_frame_loader
// PURPOSE
//  Parametrised, double-buffered input stage for the SOML decoder.
//  - Accepts one channel matrix H (NR x NT) and NR*T received samples Y per frame over valid/ready streams.
//  - Stores them in ping-pong banks and releases each completed frame to the Hq/trace core with a core_start pulse.
//  - The core reads one bank while the next frame loads into the other. Sits between the host interface and matrix_multiplier.
// PARAMETERS
//  N       32  total fixed-point word width (signed)
//  Q       22  fractional bits (carried for consistency; no arithmetic uses it)
//  NR       4  receive antennas (H rows, Y samples per slot)
//  NT       4  transmit antennas (H columns)
//  T        2  time slots of Y per frame
//  CONJ_Y   1  1: store Y imaginary part negated (conjugate); 0: store as received
// PORTS
//  clk         in   1          rising-edge clock
//  rst_n       in   1          asynchronous reset, active low
//  start       in   1          frame begin pulse
//  H_in_valid  in   1          H beat valid
//  H_in_ready  out  1          H beat accepted when valid&ready
//  H_in_r/_i   in   N each     H element, row-major: index r*NT+c
//  Y_in_valid  in   1          Y beat valid
//  Y_in_ready  out  1          Y beat accepted when valid&ready
//  Y_in_r/_i   in   N each     Y sample: slot t, antenna r at index t*NR+r
//  core_start  out  1          one-cycle pulse: read bank holds a complete frame
//  core_done   in   1          core finished with the read bank
//  H_rd_r/_i   out  NR*NT*N    read-bank H, element k at bits [k*N +: N]
//  Y_rd_r/_i   out  NR*T*N     read-bank Y, same packing
//  rd_bank     out  1          bank currently presented on H_rd/Y_rd
//  busy        out  1          state != S_IDLE
//  frame_err   out  1          one-cycle pulse: frame aborted
// BEHAVIOUR
//  - Reset: state S_IDLE, all counters 0, wr_bank=0, rd_bank=1, rd_busy=0; core_start, frame_err, readies and busy are 0.
//    Bank contents are not reset and read 0 in simulation only via an explicit clear.
//  - FSM:
//    S_IDLE -> S_LOAD on start (counters cleared).
//    S_LOAD: H_in_ready = (h_cnt < NR*NT); Y_in_ready = (y_cnt < NR*T). H and Y load independently and may be accepted in the same cycle.
//    S_LOAD -> S_COMMIT when both counts are full.
//    S_COMMIT: readies 0. If (!rd_busy || core_done): swap banks, register core_start=1, set rd_busy, go to S_IDLE.
//    Otherwise hold in S_COMMIT (back-pressure).
//  - Latency: last beat accepted in cycle t -> S_COMMIT at t+1 -> core_start high at t+2 (read bank free).
//    rd_bank and H_rd/Y_rd switch in the same cycle core_start rises. They stay stable until the next swap.
//  - rd_busy: cleared by core_done. core_done in the same cycle as a swap frees the bank, and the swap proceeds.
//  - start while in S_LOAD or S_COMMIT: frame aborted, frame_err pulses, counters cleared, state S_LOAD. Write bank is reused; read bank untouched.
//  - Beats arriving in S_IDLE are ignored (ready=0). Counters saturate at full; no wrap.
//  - CONJ_Y: stored imag = -Y_in_i, saturated (-2^(N-1) -> 2^(N-1)-1). Real parts are stored unchanged.
//  - Async reset mid-frame discards both banks' status. The core must treat rd_busy=0 as no frame available.
// STRUCTURE
//  - soml_pkg: FSM state localparams (S_IDLE, S_LOAD, S_COMMIT), clog2-based counter widths, sat_neg function.
//  - Sub-module soml_pingpong_bank: two register banks with write index/enable and registered bank-select read.
//    The FSM and handshake logic stay in the top of this file.
// TESTING
//  1. Default params, start, 16 H beats (value k<<Q) and 8 Y beats back-to-back, then idle.
//     -> core_start exactly 2 cycles after the last beat; H_rd element 5 = 5<<Q; Y_rd imag negated.
//  2. Second frame loaded while rd_busy=1 with core_done held 0.
//     -> hold in S_COMMIT with readies 0. Pulse core_done -> core_start next cycle, rd_bank toggles.
//  3. Interleaved random valid gaps on H and Y, including simultaneous accepts.
//     -> all 24 beats stored at the correct indices; no beat lost or duplicated.
//  4. start reasserted after 7 H beats -> frame_err single pulse, h_cnt=0, frame reloads cleanly; read bank unchanged.
//  5. Y_in_i = 32'h8000_0000 with CONJ_Y=1 -> stored 32'h7FFF_FFFF. Rerun with CONJ_Y=0 -> stored unchanged.
//  6. rst_n low during S_LOAD -> all outputs reach their reset values asynchronously. NR=2, NT=2, T=4 rerun of test 1 passes.

Source files
------------

// File: rtl/soml_pkg.sv
// Shared definitions for the SOML decoder input stage: FSM encodings,
// counter sizing and the saturating negation used for conjugated samples.
package soml_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    // Working width for sat_neg; callers zero-extend into it and truncate the result.
    localparam int SAT_W = 64;

    // Counter width able to hold 0..depth inclusive (a full count is a legal value).
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Two's-complement negation of a w-bit value, clamping the most negative code
    // to the most positive one instead of letting it wrap back onto itself.
    function automatic logic [SAT_W-1:0] sat_neg(input logic [SAT_W-1:0] x, input int w);
        logic [SAT_W-1:0] mask;
        logic [SAT_W-1:0] most_neg;
        mask     = (SAT_W'(1) << w) - SAT_W'(1);
        most_neg = SAT_W'(1) << (w - 1);
        if ((x & mask) == most_neg) begin
            return most_neg - SAT_W'(1);
        end
        return (SAT_W'(0) - x) & mask;
    endfunction

endpackage

// File: rtl/soml_pingpong_bank.sv
// Two-bank register store for one frame of H and Y; writes go to the selected
// write bank, and the read side registers the bank chosen by rd_sel.
module soml_pingpong_bank #(
    parameter int N       = 32,
    parameter int H_DEPTH = 16,
    parameter int Y_DEPTH = 8,
    parameter int HAW     = 5,
    parameter int YAW     = 4
) (
    input  logic                 clk,
    input  logic                 wr_bank,
    input  logic                 h_we,
    input  logic [HAW-1:0]       h_idx,
    input  logic [N-1:0]         h_wr_r,
    input  logic [N-1:0]         h_wr_i,
    input  logic                 y_we,
    input  logic [YAW-1:0]       y_idx,
    input  logic [N-1:0]         y_wr_r,
    input  logic [N-1:0]         y_wr_i,
    input  logic                 rd_sel,
    output logic [H_DEPTH*N-1:0] h_rd_r,
    output logic [H_DEPTH*N-1:0] h_rd_i,
    output logic [Y_DEPTH*N-1:0] y_rd_r,
    output logic [Y_DEPTH*N-1:0] y_rd_i
);

    genvar gi;

    // rd_sel is the next-cycle read bank, so the presented data switches on the
    // same edge as the bank pointer.
    for (gi = 0; gi < H_DEPTH; gi++) begin : g_h
        logic [N-1:0] mem_r [2];
        logic [N-1:0] mem_i [2];
        logic [N-1:0] rd_r_reg;
        logic [N-1:0] rd_i_reg;

        always_ff @(posedge clk) begin
            if (h_we && (h_idx == HAW'(gi))) begin
                mem_r[wr_bank] <= h_wr_r;
                mem_i[wr_bank] <= h_wr_i;
            end
            rd_r_reg <= mem_r[rd_sel];
            rd_i_reg <= mem_i[rd_sel];
        end

        assign h_rd_r[gi*N +: N] = rd_r_reg;
        assign h_rd_i[gi*N +: N] = rd_i_reg;
    end

    for (gi = 0; gi < Y_DEPTH; gi++) begin : g_y
        logic [N-1:0] mem_r [2];
        logic [N-1:0] mem_i [2];
        logic [N-1:0] rd_r_reg;
        logic [N-1:0] rd_i_reg;

        always_ff @(posedge clk) begin
            if (y_we && (y_idx == YAW'(gi))) begin
                mem_r[wr_bank] <= y_wr_r;
                mem_i[wr_bank] <= y_wr_i;
            end
            rd_r_reg <= mem_r[rd_sel];
            rd_i_reg <= mem_i[rd_sel];
        end

        assign y_rd_r[gi*N +: N] = rd_r_reg;
        assign y_rd_i[gi*N +: N] = rd_i_reg;
    end

endmodule

// File: rtl/soml_frame_loader.sv
// Double-buffered frame loader: collects H and Y over independent valid/ready
// streams into a write bank, then hands the bank to the core with core_start.
module soml_frame_loader
    import soml_pkg::*;
#(
    parameter int N      = 32,
    parameter int Q      = 22,
    parameter int NR     = 4,
    parameter int NT     = 4,
    parameter int T      = 2,
    parameter int CONJ_Y = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                H_in_valid,
    output logic                H_in_ready,
    input  logic [N-1:0]        H_in_r,
    input  logic [N-1:0]        H_in_i,
    input  logic                Y_in_valid,
    output logic                Y_in_ready,
    input  logic [N-1:0]        Y_in_r,
    input  logic [N-1:0]        Y_in_i,
    output logic                core_start,
    input  logic                core_done,
    output logic [NR*NT*N-1:0]  H_rd_r,
    output logic [NR*NT*N-1:0]  H_rd_i,
    output logic [NR*T*N-1:0]   Y_rd_r,
    output logic [NR*T*N-1:0]   Y_rd_i,
    output logic                rd_bank,
    output logic                busy,
    output logic                frame_err
);

    localparam int H_DEPTH = NR * NT;
    localparam int Y_DEPTH = NR * T;
    localparam int HCW     = cnt_width(H_DEPTH);
    localparam int YCW     = cnt_width(Y_DEPTH);
    localparam logic [HCW-1:0] H_FULL = HCW'(H_DEPTH);
    localparam logic [YCW-1:0] Y_FULL = YCW'(Y_DEPTH);

    // Q only documents the number format; reject formats with no integer sign bit.
    if (Q >= N) begin : g_q_range
        $error("soml_frame_loader: Q must be smaller than N");
    end

    logic [1:0]     state_reg;
    logic [HCW-1:0] h_cnt_reg;
    logic [HCW-1:0] h_cnt_next;
    logic [YCW-1:0] y_cnt_reg;
    logic [YCW-1:0] y_cnt_next;
    logic           wr_bank_reg;
    logic           rd_bank_reg;
    logic           rd_bank_next;
    logic           rd_busy_reg;
    logic           core_start_reg;
    logic           frame_err_reg;

    logic           h_fire;
    logic           y_fire;
    logic           restart;
    logic           swap;
    logic [N-1:0]   y_store_i;

    assign H_in_ready = (state_reg == S_LOAD) && (h_cnt_reg < H_FULL);
    assign Y_in_ready = (state_reg == S_LOAD) && (y_cnt_reg < Y_FULL);
    assign h_fire     = H_in_valid && H_in_ready;
    assign y_fire     = Y_in_valid && Y_in_ready;
    assign h_cnt_next = h_fire ? h_cnt_reg + HCW'(1) : h_cnt_reg;
    assign y_cnt_next = y_fire ? y_cnt_reg + YCW'(1) : y_cnt_reg;

    // A start seen mid-frame aborts it; it also wins over a pending swap.
    assign restart      = start && (state_reg != S_IDLE);
    assign swap         = (state_reg == S_COMMIT) && !start && (!rd_busy_reg || core_done);
    assign rd_bank_next = swap ? wr_bank_reg : rd_bank_reg;

    if (CONJ_Y != 0) begin : g_conj
        assign y_store_i = N'(sat_neg(SAT_W'(Y_in_i), N));
    end else begin : g_plain
        assign y_store_i = Y_in_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            h_cnt_reg      <= '0;
            y_cnt_reg      <= '0;
            wr_bank_reg    <= 1'b0;
            rd_bank_reg    <= 1'b1;
            rd_busy_reg    <= 1'b0;
            core_start_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            core_start_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            if (core_done) begin
                rd_busy_reg <= 1'b0;
            end
            if (restart) begin
                frame_err_reg <= 1'b1;
                h_cnt_reg     <= '0;
                y_cnt_reg     <= '0;
                state_reg     <= S_LOAD;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (start) begin
                            h_cnt_reg <= '0;
                            y_cnt_reg <= '0;
                            state_reg <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        h_cnt_reg <= h_cnt_next;
                        y_cnt_reg <= y_cnt_next;
                        if ((h_cnt_next == H_FULL) && (y_cnt_next == Y_FULL)) begin
                            state_reg <= S_COMMIT;
                        end
                    end
                    S_COMMIT: begin
                        if (swap) begin
                            wr_bank_reg    <= ~wr_bank_reg;
                            rd_bank_reg    <= wr_bank_reg;
                            rd_busy_reg    <= 1'b1;
                            core_start_reg <= 1'b1;
                            state_reg      <= S_IDLE;
                        end
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    soml_pingpong_bank #(
        .N       (N),
        .H_DEPTH (H_DEPTH),
        .Y_DEPTH (Y_DEPTH),
        .HAW     (HCW),
        .YAW     (YCW)
    ) u_bank (
        .clk     (clk),
        .wr_bank (wr_bank_reg),
        .h_we    (h_fire && !start),
        .h_idx   (h_cnt_reg),
        .h_wr_r  (H_in_r),
        .h_wr_i  (H_in_i),
        .y_we    (y_fire && !start),
        .y_idx   (y_cnt_reg),
        .y_wr_r  (Y_in_r),
        .y_wr_i  (y_store_i),
        .rd_sel  (rd_bank_next),
        .h_rd_r  (H_rd_r),
        .h_rd_i  (H_rd_i),
        .y_rd_r  (Y_rd_r),
        .y_rd_i  (Y_rd_i)
    );

    assign core_start = core_start_reg;
    assign frame_err  = frame_err_reg;
    assign rd_bank    = rd_bank_reg;
    assign busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_soml_frame_loader.sv
// Directed bench for soml_frame_loader: a default-parameter instance checked
// through a frame scoreboard, plus a small NR=2/NT=2/T=4 unconjugated instance.
module tb_soml_frame_loader;

    localparam int N   = 32;
    localparam int Q   = 22;
    localparam int HD  = 16;
    localparam int YD  = 8;
    localparam int HD2 = 4;
    localparam int YD2 = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic start, h_valid, y_valid, core_done;
    logic h_ready, y_ready, core_start, rd_bank, busy, frame_err;
    logic [N-1:0] h_r, h_i, y_r, y_i;
    logic [HD*N-1:0] h_rd_r, h_rd_i;
    logic [YD*N-1:0] y_rd_r, y_rd_i;

    logic start2, h_valid2, y_valid2, core_done2;
    logic h_ready2, y_ready2, core_start2, rd_bank2, busy2, frame_err2;
    logic [N-1:0] h_r2, h_i2, y_r2, y_i2;
    logic [HD2*N-1:0] h_rd_r2, h_rd_i2;
    logic [YD2*N-1:0] y_rd_r2, y_rd_i2;

    soml_frame_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .H_in_valid(h_valid), .H_in_ready(h_ready), .H_in_r(h_r), .H_in_i(h_i),
        .Y_in_valid(y_valid), .Y_in_ready(y_ready), .Y_in_r(y_r), .Y_in_i(y_i),
        .core_start(core_start), .core_done(core_done),
        .H_rd_r(h_rd_r), .H_rd_i(h_rd_i), .Y_rd_r(y_rd_r), .Y_rd_i(y_rd_i),
        .rd_bank(rd_bank), .busy(busy), .frame_err(frame_err)
    );

    soml_frame_loader #(.N(N), .Q(Q), .NR(2), .NT(2), .T(4), .CONJ_Y(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .H_in_valid(h_valid2), .H_in_ready(h_ready2), .H_in_r(h_r2), .H_in_i(h_i2),
        .Y_in_valid(y_valid2), .Y_in_ready(y_ready2), .Y_in_r(y_r2), .Y_in_i(y_i2),
        .core_start(core_start2), .core_done(core_done2),
        .H_rd_r(h_rd_r2), .H_rd_i(h_rd_i2), .Y_rd_r(y_rd_r2), .Y_rd_i(y_rd_i2),
        .rd_bank(rd_bank2), .busy(busy2), .frame_err(frame_err2)
    );

    int checks = 0;
    int errors = 0;
    int frames_seen = 0;

    logic [HD*N-1:0] exp_hr_q[$], exp_hi_q[$];
    logic [YD*N-1:0] exp_yr_q[$], exp_yi_q[$];
    logic [HD*N-1:0] last_hr;

    logic [N-1:0] hr[HD], hi[HD], yr[YD], yi[YD];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] conj_model(input logic [N-1:0] x);
        if (x == 32'h8000_0000) return 32'h7FFF_FFFF;
        return -x;
    endfunction

    task automatic fill_frame(input int f);
        for (int k = 0; k < HD; k++) begin
            hr[k] = (32'(k) << Q) + 32'(f);
            hi[k] = $urandom;
        end
        for (int k = 0; k < YD; k++) begin
            yr[k] = $urandom;
            yi[k] = $urandom;
        end
        yi[0] = 32'h0000_0000;
        yi[3] = 32'h8000_0000;
    endtask

    task automatic push_expected();
        logic [HD*N-1:0] pr, pi;
        logic [YD*N-1:0] qr, qi;
        for (int k = 0; k < HD; k++) begin
            pr[k*N +: N] = hr[k];
            pi[k*N +: N] = hi[k];
        end
        for (int k = 0; k < YD; k++) begin
            qr[k*N +: N] = yr[k];
            qi[k*N +: N] = conj_model(yi[k]);
        end
        exp_hr_q.push_back(pr);
        exp_hi_q.push_back(pi);
        exp_yr_q.push_back(qr);
        exp_yi_q.push_back(qi);
        last_hr = pr;
    endtask

    // Drives up to h_limit H beats and y_limit Y beats; returns on the falling
    // edge right after the final accepting rising edge.
    task automatic load_frame(input bit do_start, input bit gaps, input int h_limit, input int y_limit);
        int hk = 0;
        int yk = 0;
        int budget = 0;
        bit ha, ya;
        if (h_limit == HD && y_limit == YD) push_expected();
        if (do_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        while ((hk < h_limit || yk < y_limit) && budget < 400) begin
            h_valid = (hk < h_limit) && (!gaps || $urandom_range(0, 2) != 0);
            y_valid = (yk < y_limit) && (!gaps || $urandom_range(0, 2) != 0);
            if (hk < HD) begin h_r = hr[hk]; h_i = hi[hk]; end
            if (yk < YD) begin y_r = yr[yk]; y_i = yi[yk]; end
            #1;
            ha = h_valid && h_ready;
            ya = y_valid && y_ready;
            @(posedge clk);
            if (ha) hk++;
            if (ya) yk++;
            @(negedge clk);
            h_valid = 1'b0;
            y_valid = 1'b0;
            budget++;
        end
        chk("load_within_budget", budget < 400, 1);
    endtask

    task automatic pulse_done();
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (core_start === 1'b1) begin
            frames_seen++;
            $display("frame %0d released on read bank %0d", frames_seen, rd_bank);
            chk("sb_frame_pending", exp_hr_q.size() != 0, 1);
            if (exp_hr_q.size() != 0) begin
                chk("sb_h_r", h_rd_r, exp_hr_q.pop_front());
                chk("sb_h_i", h_rd_i, exp_hi_q.pop_front());
                chk("sb_y_r", y_rd_r, exp_yr_q.pop_front());
                chk("sb_y_i", y_rd_i, exp_yi_q.pop_front());
            end
        end
    end

    initial begin
        logic [N-1:0] e5;
        logic [HD2*N-1:0] e2_hr, e2_hi;
        logic [YD2*N-1:0] e2_yr, e2_yi;

        start = 0; h_valid = 0; y_valid = 0; core_done = 0;
        h_r = 0; h_i = 0; y_r = 0; y_i = 0;
        start2 = 0; h_valid2 = 0; y_valid2 = 0; core_done2 = 0;
        h_r2 = 0; h_i2 = 0; y_r2 = 0; y_i2 = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_core_start", core_start, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_h_ready", h_ready, 0);
        chk("rst_y_ready", y_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_bank", rd_bank, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back frame; core_start two cycles after the last beat.
        fill_frame(0);
        load_frame(1, 0, HD, YD);
        chk("t1_cs_t1", core_start, 0);
        @(negedge clk);
        chk("t1_cs_t2", core_start, 1);
        e5 = 32'd5 << Q;
        chk("t1_h_el5", h_rd_r[5*N +: N], e5);
        chk("t1_y_conj_sat", y_rd_i[3*N +: N], 32'h7FFF_FFFF);
        chk("t1_rd_bank", rd_bank, 0);
        @(negedge clk);
        chk("t1_cs_single", core_start, 0);
        chk("t1_idle", busy, 0);

        // Second frame while the read bank is still owned by the core.
        fill_frame(1);
        load_frame(1, 0, HD, YD);
        for (int c = 0; c < 3; c++) begin
            chk("t2_hold_busy", busy, 1);
            chk("t2_hold_h_ready", h_ready, 0);
            chk("t2_hold_y_ready", y_ready, 0);
            chk("t2_hold_no_cs", core_start, 0);
            chk("t2_hold_rd_bank", rd_bank, 0);
            @(negedge clk);
        end
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        chk("t2_cs_after_done", core_start, 1);
        chk("t2_rd_bank", rd_bank, 1);
        @(negedge clk);

        // Random valid gaps on both streams.
        pulse_done();
        fill_frame(2);
        load_frame(1, 1, HD, YD);
        chk("t3_cs_t1", core_start, 0);
        @(negedge clk);
        chk("t3_cs_t2", core_start, 1);
        chk("t3_rd_bank", rd_bank, 0);
        @(negedge clk);

        // Abort after 7 H beats, then reload the same write bank.
        pulse_done();
        fill_frame(3);
        load_frame(1, 0, 7, 3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_frame_err", frame_err, 1);
        chk("t4_h_cnt", dut.h_cnt_reg, 0);
        chk("t4_busy", busy, 1);
        chk("t4_h_ready", h_ready, 1);
        chk("t4_rd_bank_kept", rd_bank, 0);
        chk("t4_rd_data_kept", h_rd_r, last_hr);
        @(negedge clk);
        chk("t4_frame_err_single", frame_err, 0);
        fill_frame(4);
        load_frame(0, 0, HD, YD);
        chk("t4_cs_t1", core_start, 0);
        @(negedge clk);
        chk("t4_cs_t2", core_start, 1);
        chk("t4_rd_bank", rd_bank, 1);
        @(negedge clk);

        // Asynchronous reset in the middle of a load.
        pulse_done();
        fill_frame(5);
        load_frame(1, 0, 5, 2);
        chk("t6_loading", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_h_ready", h_ready, 0);
        chk("t6_y_ready", y_ready, 0);
        chk("t6_rd_bank", rd_bank, 1);
        chk("t6_core_start", core_start, 0);
        chk("t6_frame_err", frame_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill_frame(6);
        load_frame(1, 1, HD, YD);
        chk("t6_cs_t1", core_start, 0);
        @(negedge clk);
        chk("t6_cs_t2", core_start, 1);
        chk("t6_rd_bank", rd_bank, 0);
        @(negedge clk);

        // Small geometry, no conjugation.
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int k = 0; k < YD2; k++) begin
            h_valid2 = (k < HD2);
            h_r2 = 32'(k) << Q;
            h_i2 = 32'(k + 100);
            y_valid2 = 1'b1;
            y_r2 = 32'(k * 11 + 3);
            y_i2 = (k == 1) ? 32'h8000_0000 : 32'(k * 5);
            if (k < HD2) begin
                chk("d2_h_ready", h_ready2, 1);
                e2_hr[k*N +: N] = h_r2;
                e2_hi[k*N +: N] = h_i2;
            end
            chk("d2_y_ready", y_ready2, 1);
            e2_yr[k*N +: N] = y_r2;
            e2_yi[k*N +: N] = y_i2;
            @(negedge clk);
        end
        h_valid2 = 1'b0;
        y_valid2 = 1'b0;
        chk("d2_cs_t1", core_start2, 0);
        @(negedge clk);
        chk("d2_cs_t2", core_start2, 1);
        $display("small frame released on read bank %0d", rd_bank2);
        chk("d2_h_r", h_rd_r2, e2_hr);
        chk("d2_h_i", h_rd_i2, e2_hi);
        chk("d2_y_r", y_rd_r2, e2_yr);
        chk("d2_y_i", y_rd_i2, e2_yi);
        chk("d2_y_min_kept", y_rd_i2[1*N +: N], 32'h8000_0000);
        chk("d2_rd_bank", rd_bank2, 0);

        @(negedge clk);
        chk("sb_drained", exp_hr_q.size(), 0);
        chk("sb_frames_seen", frames_seen, 5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
